// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch queue between the PC generator, a pipelined in-order
//   instruction memory and Decode.
// Latency: a response is visible on valid_F the cycle after it arrives (same cycle with
//   FETCH_QUEUE_BYPASS_EN defined); steady state delivers one instruction per cycle.
// Backpressure: Decode stalls with ready_D; requests stop once DEPTH entries are allocated
//   (in flight plus filled); memory responses cannot be stalled and are always absorbed.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, a response landing in the
//   head entry is presented on valid_F/Instr_F combinationally (and may pop that cycle).
//
// Ports:
//   clk, rst                     clock (rising edge) and asynchronous active-low reset
//   PCSrc_E, PCTarget_E          redirect from Execute: flushes the queue, refetches at target
//   imem_req_valid/ready/addr    fetch request channel (valid/ready)
//   imem_rsp_valid/data          in-order response channel, no backpressure
//   valid_F, ready_D, PC_F, Instr_F   head instruction towards Decode (valid/ready)
module fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,   // power of two, 2..16
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrc_E,
    input  logic [XLEN-1:0] PCTarget_E,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            valid_F,
    input  logic            ready_D,
    output logic [XLEN-1:0] PC_F,
    output logic [31:0]     Instr_F
);

    localparam int PW = $clog2(DEPTH);  // ring pointer width
    localparam int CW = PW + 1;         // occupancy counters, 0..DEPTH
    // Drop counter: responses still owed by memory for squashed fetches. Back-to-back
    // redirects can stack one queue's worth of stale fetches on top of the previous one.
    localparam int DW = PW + 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   alloc_q, alloc_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic [PW-1:0]   head_q, head_d;
    logic [CW-1:0]   count_q, count_d;        // allocated entries (in flight + filled)
    logic [CW-1:0]   inflight_q, inflight_d;  // allocated but not yet filled
    logic [DW-1:0]   drop_q, drop_d;
    logic [DEPTH-1:0] filled_q, filled_d;

    // Payload storage needs no reset: nothing reads it unless its filled bit is set.
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic            req_fire;
    logic            rsp_take;   // response written into the queue
    logic            rsp_drop;   // response belonging to a squashed fetch
    logic            head_filled;
    logic            byp_hit;    // response filling the head entry this very cycle
    logic            pop;
    logic [DW-1:0]   drop_sum;

    // Gating with rst keeps the request channel quiet while memory is held in reset too.
    assign imem_req_valid = rst && (count_q < CW'(DEPTH)) && !PCSrc_E;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response in the redirect cycle is never written; it is accounted for in drop_sum.
    assign rsp_take    = rst && imem_rsp_valid && !PCSrc_E && (drop_q == '0);
    assign rsp_drop    = imem_rsp_valid && (drop_q != '0);
    assign head_filled = filled_q[head_q];

`ifdef FETCH_QUEUE_BYPASS_EN
    // With responses in order, fill_q == head_q means the response is for the head entry.
    assign byp_hit = rsp_take && (fill_q == head_q) && !head_filled;
`else
    assign byp_hit = 1'b0;
`endif

    assign valid_F = !PCSrc_E && (head_filled || byp_hit);
    assign pop     = valid_F && ready_D;
    assign PC_F    = valid_F ? pc_q[head_q] : '0;
    assign Instr_F = !valid_F ? 32'h0 : (byp_hit ? imem_rsp_data : instr_q[head_q]);

    // Old responses still owed after a redirect: pending drops plus every unfilled entry.
    assign drop_sum = drop_q + DW'(inflight_q);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        head_d     = head_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        filled_d   = filled_q;

        if (PCSrc_E) begin
            fetch_pc_d = PCTarget_E;
            alloc_d    = '0;
            fill_d     = '0;
            head_d     = '0;
            count_d    = '0;
            inflight_d = '0;
            filled_d   = '0;
            // A response arriving now is the oldest owed one and is discarded on the spot.
            drop_d     = (imem_rsp_valid && (drop_sum != '0)) ? drop_sum - DW'(1) : drop_sum;
        end else begin
            if (req_fire) begin
                alloc_d    = alloc_q + PW'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end

            if (rsp_take) begin
                fill_d           = fill_q + PW'(1);
                filled_d[fill_q] = 1'b1;
            end else if (rsp_drop) begin
                drop_d = drop_q - DW'(1);
            end

            // Applied after the fill so a bypassed entry popped in the same cycle ends empty.
            if (pop) begin
                head_d           = head_q + PW'(1);
                filled_d[head_q] = 1'b0;
            end

            count_d    = count_q + CW'(req_fire) - CW'(pop);
            inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            filled_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            head_q     <= head_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            filled_q   <= filled_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_q[alloc_q] <= fetch_pc_q;
        end
        if (rsp_take) begin
            instr_q[fill_q] <= imem_rsp_data;
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count_q <= CW'(DEPTH));
    a_inflight_bound: assert property (@(posedge clk) disable iff (!rst)
        inflight_q <= count_q);

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int          XLEN     = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            PCSrc_E = 1'b0;
    logic [XLEN-1:0] PCTarget_E = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = '0;
    logic            valid_F;
    logic            ready_D = 1'b0;
    logic [XLEN-1:0] PC_F;
    logic [31:0]     Instr_F;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .valid_F(valid_F), .ready_D(ready_D),
        .PC_F(PC_F), .Instr_F(Instr_F)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] qget(input logic [63:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    // ---------------- memory + reference model ----------------
    typedef struct { logic [31:0] data; int due; } mem_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; bit filled; } ent_t;

    mem_t        mem_q[$];     // outstanding memory responses, in order
    int          last_due = 0;
    int          lat_lo = 1, lat_hi = 1;
    ent_t        m_q[$];       // queue contents, oldest first
    logic [63:0] m_pc = RESET_PC;
    int          m_drop = 0;   // stale responses still to discard
    logic [63:0] hs_addr[$];   // accepted request addresses
    logic [63:0] pop_pc[$];    // PCs handed to Decode
    int          first_vf = -1;
    int          base_cyc = 0;

    always @(negedge clk) begin
        int          nf;
        int          unf;
        int          due;
        bit          e_req;
        bit          take;
        bit          byp;
        bit          e_vf;
        logic [63:0] e_pcf;
        logic [31:0] e_ins;
        if (!rst) begin
            m_q.delete();
            mem_q.delete();
            m_pc     = RESET_PC;
            m_drop   = 0;
            last_due = 0;
            chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            chk("rst_valid_F", 64'(valid_F), 64'd0);
            chk("rst_PC_F", PC_F, 64'd0);
            chk("rst_Instr_F", 64'(Instr_F), 64'd0);
        end else begin
            nf  = -1;
            unf = 0;
            foreach (m_q[i]) begin
                if (!m_q[i].filled) begin
                    if (nf < 0) nf = i;
                    unf++;
                end
            end
            e_req = (m_q.size() < DEPTH) && !PCSrc_E;
            take  = imem_rsp_valid && !PCSrc_E && (m_drop == 0);
            byp   = BYP && take && (nf == 0);
            e_vf  = !PCSrc_E && (m_q.size() > 0) && (m_q[0].filled || byp);
            e_pcf = e_vf ? m_q[0].pc : 64'd0;
            e_ins = !e_vf ? 32'd0 : (m_q[0].filled ? m_q[0].instr : imem_rsp_data);

            chk("req_valid", 64'(imem_req_valid), 64'(e_req));
            chk("req_addr", imem_req_addr, m_pc);
            chk("valid_F", 64'(valid_F), 64'(e_vf));
            chk("PC_F", PC_F, e_pcf);
            chk("Instr_F", 64'(Instr_F), 64'(e_ins));
            if (first_vf < 0 && valid_F === 1'b1) first_vf = cyc - base_cyc;

            if (PCSrc_E) begin
                m_drop = m_drop + unf - (imem_rsp_valid ? 1 : 0);
                if (m_drop < 0) m_drop = 0;
                m_q.delete();
                m_pc = PCTarget_E;
            end else begin
                if (imem_rsp_valid) begin
                    if (m_drop > 0) m_drop--;
                    else if (nf < 0) chk("rsp_without_request", 64'd1, 64'd0);
                    else begin
                        m_q[nf].instr  = imem_rsp_data;
                        m_q[nf].filled = 1'b1;
                    end
                end
                if (e_vf && ready_D) begin
                    pop_pc.push_back(m_q[0].pc);
                    void'(m_q.pop_front());
                end
                if (e_req && imem_req_ready) begin
                    due = cyc + int'($urandom_range(lat_hi, lat_lo));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem_q.push_back('{data: $urandom, due: due});
                    hs_addr.push_back(m_pc);
                    m_q.push_back('{pc: m_pc, instr: 32'h0, filled: 1'b0});
                    m_pc = m_pc + 64'd4;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_rsp();
        if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_rsp();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        PCSrc_E = 1'b0;
        imem_req_ready = 1'b0;
        ready_D = 1'b0;
        imem_rsp_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        hs_addr.delete();
        pop_pc.delete();
        first_vf = -1;
        base_cyc = cyc;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("init_req_valid", 64'(imem_req_valid), 64'd0);
        chk("init_valid_F", 64'(valid_F), 64'd0);

        // Streaming with 1-cycle memory and Decode always ready.
        do_reset();
        ready_D = 1'b1; imem_req_ready = 1'b1; lat_lo = 1; lat_hi = 1;
        run(12);
        chk("s_req0", qget(hs_addr, 0), 64'h0);
        chk("s_req1", qget(hs_addr, 1), 64'h4);
        chk("s_req2", qget(hs_addr, 2), 64'h8);
        chk("s_pop0", qget(pop_pc, 0), 64'h0);
        chk("s_pop1", qget(pop_pc, 1), 64'h4);
        chk("s_pop2", qget(pop_pc, 2), 64'h8);
        chk("s_first_valid", 64'(first_vf), BYP ? 64'd1 : 64'd2);
        chk("s_pop_count", 64'(pop_pc.size()), BYP ? 64'd11 : 64'd10);

        // Decode stalled: queue fills with exactly DEPTH requests.
        do_reset();
        ready_D = 1'b0; imem_req_ready = 1'b1;
        run(10);
        chk("full_req_count", 64'(hs_addr.size()), 64'd4);
        chk("full_last_addr", qget(hs_addr, 3), 64'hC);
        chk("full_req_valid", 64'(imem_req_valid), 64'd0);
        ready_D = 1'b1;
        run(6);
        chk("full_resume_addr", qget(hs_addr, 4), 64'h10);

        // Two fetches in flight when a redirect arrives.
        do_reset();
        ready_D = 1'b0; imem_req_ready = 1'b1; lat_lo = 3; lat_hi = 3;
        run(2);
        imem_req_ready = 1'b0; PCSrc_E = 1'b1; PCTarget_E = 64'h100;
        tick();
        chk("r2_drop", 64'(m_drop), 64'd2);
        PCSrc_E = 1'b0; imem_req_ready = 1'b1; ready_D = 1'b1;
        pop_pc.delete();
        run(12);
        chk("r2_first_pop", qget(pop_pc, 0), 64'h100);

        // Redirect coinciding with a response and a would-be pop.
        do_reset();
        ready_D = 1'b0; imem_req_ready = 1'b1; lat_lo = 2; lat_hi = 2;
        run(3);
        PCSrc_E = 1'b1; PCTarget_E = 64'h100; ready_D = 1'b1;
        chk("rc_rsp_present", 64'(imem_rsp_valid), 64'd1);
        @(negedge clk);
        #1;
        chk("rc_valid_F", 64'(valid_F), 64'd0);
        tick();
        chk("rc_drop", 64'(m_drop), 64'd1);
        PCSrc_E = 1'b0;
        hs_addr.delete();
        pop_pc.delete();
        run(10);
        chk("rc_next_req", qget(hs_addr, 0), 64'h100);
        chk("rc_first_pop", qget(pop_pc, 0), 64'h100);

        // Asynchronous reset mid-stream with three entries held.
        do_reset();
        ready_D = 1'b0; imem_req_ready = 1'b1; lat_lo = 1; lat_hi = 1;
        run(3);
        imem_req_ready = 1'b0;
        run(3);
        chk("ar_pre_valid_F", 64'(valid_F), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_req_valid", 64'(imem_req_valid), 64'd0);
        chk("ar_valid_F", 64'(valid_F), 64'd0);
        chk("ar_PC_F", PC_F, 64'd0);
        chk("ar_Instr_F", 64'(Instr_F), 64'd0);
        tick();
        tick();
        rst = 1'b1; imem_req_ready = 1'b1;
        hs_addr.delete();
        run(1);
        chk("ar_first_req", qget(hs_addr, 0), RESET_PC);

        // Randomized traffic: variable latency, stalls, redirects (including near XLEN wrap).
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            ready_D        = ($urandom_range(0, 9) < 7);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            PCSrc_E        = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) PCTarget_E = 64'hFFFF_FFFF_FFFF_FFF4;
            else PCTarget_E = {$urandom, $urandom} & ~64'h3;
            tick();
        end
        PCSrc_E = 1'b0;
        run(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
